vx_tcu_drl_align_seq: RTL and testbench

Multi-beat exponent-alignment sequencer for the TCU DRL adder-tree front end. It accepts a dot-product block of up to `BEATS × N` exponents, delivered `N` per beat, and buffers the beats while tracking the block-wide maximum exponent. It then replays the buffered beats, emitting per-lane right-shift amounts relative to the block maximum. It sits between the product-exponent stage and the mantissa alignment shifters, so that blocks wider than one `N`-lane max-exponent unit align to a single common exponent.

---
 rtl/vx_tcu_drl_align_seq_pkg.sv | 21 ++
 rtl/vx_tcu_drl_align_seq_max_exp.sv | 31 +++
 rtl/vx_tcu_drl_align_seq.sv | 161 ++++++++++++++++
 tb/tb_vx_tcu_drl_align_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_tcu_drl_align_seq_pkg.sv
// Shared types and constants for the TCU DRL multi-beat exponent aligner.
package VX_tcu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPLAY  = 2'd2
    } tcu_align_state_e;

    localparam int TCU_DRL_SHIFT_W = 8;
    localparam logic [TCU_DRL_SHIFT_W-1:0] TCU_DRL_SHIFT_SAT = 8'hFF;

    // Clamp a non-negative exponent difference to the shifter range.
    function automatic logic [TCU_DRL_SHIFT_W-1:0] sat_shift(input logic [31:0] diff);
        if (|diff[31:TCU_DRL_SHIFT_W]) begin
            return TCU_DRL_SHIFT_SAT;
        end
        return diff[TCU_DRL_SHIFT_W-1:0];
    endfunction

endpackage

// File: rtl/vx_tcu_drl_align_seq_max_exp.sv
// Single-beat signed maximum exponent unit with per-lane shift to that maximum.
module VX_tcu_drl_max_exp
    import VX_tcu_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 8
) (
    input  logic [N-1:0][WIDTH-1:0]           exps_i,
    output logic [WIDTH-1:0]                  max_exp_o,
    output logic [N-1:0][TCU_DRL_SHIFT_W-1:0] shift_o
);

    localparam int DW = WIDTH + 1;

    // Linear signed-max scan across the lanes of one beat.
    always_comb begin
        max_exp_o = exps_i[0];
        for (int i = 1; i < N; i++) begin
            if ($signed(exps_i[i]) > $signed(max_exp_o)) begin
                max_exp_o = exps_i[i];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_shift
        logic [DW-1:0] diff;
        assign diff        = DW'($signed(max_exp_o)) - DW'($signed(exps_i[gi]));
        assign shift_o[gi] = sat_shift(32'(diff));
    end

endmodule

// File: rtl/vx_tcu_drl_align_seq.sv
// Multi-beat exponent-alignment sequencer: buffers up to BEATS beats of a block
// while tracking the block maximum, then replays per-lane shifts to that maximum.
module vx_tcu_drl_align_seq
    import VX_tcu_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 8,
    parameter int BEATS = 4,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N-1:0][WIDTH-1:0]           in_exps,
    input  logic [N-1:0]                      in_mask,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N-1:0][TCU_DRL_SHIFT_W-1:0] out_shift,
    output logic [WIDTH-1:0]                  out_max,
    output logic [BEAT_W-1:0]                 out_beat,
    output logic                              out_last,
    output logic                              ovf
);

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int DW    = WIDTH + 1;
    localparam logic [WIDTH-1:0] EXP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    tcu_align_state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] rcnt_q, rcnt_d;
    logic [WIDTH-1:0]  run_max_q, run_max_d;
    logic              ovf_q, ovf_d;

    // Beat buffer; contents are only meaningful for slots written in the current block.
    logic [N-1:0][WIDTH-1:0] buf_exps_q [BEATS];
    logic [N-1:0]            buf_mask_q [BEATS];

    logic [N-1:0][WIDTH-1:0]           beat_exps;
    logic [WIDTH-1:0]                  beat_max;
    logic [N-1:0][TCU_DRL_SHIFT_W-1:0] unused_beat_shift;

    logic              accept;
    logic              handshake;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_full;
    logic              block_end;
    logic              rd_last;
    logic [BEAT_W-1:0] wr_idx;
    logic [WIDTH-1:0]  run_max_merge;
    logic [N-1:0][WIDTH-1:0] rd_exps;
    logic [N-1:0]            rd_mask;

    // Masked lanes become the most negative exponent so they never win the max.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign beat_exps[gi] = in_mask[gi] ? in_exps[gi] : EXP_MIN;
    end

    VX_tcu_drl_max_exp #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_max_exp (
        .exps_i    (beat_exps),
        .max_exp_o (beat_max),
        .shift_o   (unused_beat_shift)
    );

    assign in_ready  = (state_q != REPLAY);
    assign out_valid = (state_q == REPLAY);
    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;

    // IDLE always starts a fresh block at slot 0 regardless of stale counters.
    assign wr_idx    = (state_q == IDLE) ? '0 : cnt_q[BEAT_W-1:0];
    assign cnt_inc   = (state_q == IDLE) ? CNT_W'(1) : (cnt_q + CNT_W'(1));
    assign cnt_full  = (cnt_inc == CNT_W'(BEATS));
    assign block_end = accept & (in_last | cnt_full);

    assign run_max_merge = ((state_q == IDLE) || ($signed(beat_max) > $signed(run_max_q)))
                         ? beat_max : run_max_q;

    assign rd_last = (CNT_W'(rcnt_q) == (cnt_q - CNT_W'(1)));

    // Next-state logic for the collect/replay sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        run_max_d = run_max_q;
        ovf_d     = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    cnt_d     = cnt_inc;
                    run_max_d = run_max_merge;
                    ovf_d     = cnt_full & ~in_last;
                    if (block_end) begin
                        rcnt_d  = '0;
                        state_d = REPLAY;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            REPLAY: begin
                if (handshake) begin
                    rcnt_d = rcnt_q + BEAT_W'(1);
                    if (rd_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers; reset discards any partial block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            run_max_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            run_max_q <= run_max_d;
            ovf_q     <= ovf_d;
        end
    end

    // Beat buffer write on every accepted input beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_exps_q[wr_idx] <= in_exps;
            buf_mask_q[wr_idx] <= in_mask;
        end
    end

    assign rd_exps = buf_exps_q[rcnt_q];
    assign rd_mask = buf_mask_q[rcnt_q];

    // Replay shifts: block max minus lane exponent, saturated; masked lanes fully shifted out.
    for (genvar gi = 0; gi < N; gi++) begin : g_out
        logic [DW-1:0] diff;
        assign diff = DW'($signed(run_max_q)) - DW'($signed(rd_exps[gi]));
        assign out_shift[gi] = !out_valid   ? '0 :
                               !rd_mask[gi] ? TCU_DRL_SHIFT_SAT :
                                              sat_shift(32'(diff));
    end

    assign out_max  = run_max_q;
    assign out_beat = out_valid ? rcnt_q : '0;
    assign out_last = out_valid & rd_last;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_vx_tcu_drl_align_seq.sv
// Directed scoreboard bench for the multi-beat exponent-alignment sequencer.
module tb_vx_tcu_drl_align_seq;

    localparam int N = 5;
    localparam int W = 8;
    localparam int WX = 10;
    localparam int BEATS = 4;

    typedef struct packed {
        logic [N-1:0][7:0] shift;
        logic [7:0]        mx;
        logic [1:0]        beat;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic                in_valid, in_ready, in_last;
    logic [N-1:0][W-1:0] in_exps;
    logic [N-1:0]        in_mask;
    logic                out_valid, out_ready, out_last, ovf;
    logic [N-1:0][7:0]   out_shift;
    logic [W-1:0]        out_max;
    logic [1:0]          out_beat;

    logic                 x_in_valid, x_in_ready, x_in_last;
    logic [N-1:0][WX-1:0] x_in_exps;
    logic [N-1:0]         x_in_mask;
    logic                 x_out_valid, x_out_ready, x_out_last, x_ovf;
    logic [N-1:0][7:0]    x_out_shift;
    logic [WX-1:0]        x_out_max;
    logic [1:0]           x_out_beat;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    vx_tcu_drl_align_seq #(.N(N), .WIDTH(W), .BEATS(BEATS)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exps   (in_exps),
        .in_mask   (in_mask),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_shift (out_shift),
        .out_max   (out_max),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    vx_tcu_drl_align_seq #(.N(N), .WIDTH(WX), .BEATS(BEATS)) u_dut_w10 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (x_in_valid),
        .in_ready  (x_in_ready),
        .in_exps   (x_in_exps),
        .in_mask   (x_in_mask),
        .in_last   (x_in_last),
        .out_valid (x_out_valid),
        .out_ready (x_out_ready),
        .out_shift (x_out_shift),
        .out_max   (x_out_max),
        .out_beat  (x_out_beat),
        .out_last  (x_out_last),
        .ovf       (x_ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [N-1:0][7:0] mk8(input int a0, input int a1, input int a2,
                                              input int a3, input int a4);
        logic [N-1:0][7:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3); r[4] = 8'(a4);
        return r;
    endfunction

    function automatic logic [N-1:0][WX-1:0] mk10(input int a0, input int a1, input int a2,
                                                  input int a3, input int a4);
        logic [N-1:0][WX-1:0] r;
        r[0] = WX'(a0); r[1] = WX'(a1); r[2] = WX'(a2); r[3] = WX'(a3); r[4] = WX'(a4);
        return r;
    endfunction

    function automatic logic [N-1:0][7:0] all8(input int a);
        return mk8(a, a, a, a, a);
    endfunction

    task automatic push(input logic [N-1:0][7:0] s, input int mx, input int b, input logic l);
        exp_t e;
        e.shift = s;
        e.mx    = 8'(mx);
        e.beat  = 2'(b);
        e.last  = l;
        sb_q.push_back(e);
    endtask

    // Drive one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [N-1:0][7:0] e, input logic [N-1:0] m, input logic l);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_exps  = e;
        in_mask  = m;
        in_last  = l;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((out_valid || !in_ready) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("idle_reached", 64'({out_valid, in_ready}), 64'b01);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_shift"}, 64'(out_shift), 64'd0);
        chk({tag, "_out_max"},   64'(out_max),   64'd0);
        chk({tag, "_out_beat"},  64'(out_beat),  64'd0);
        chk({tag, "_out_last"},  64'(out_last),  64'd0);
        chk({tag, "_ovf"},       64'(ovf),       64'd0);
    endtask

    // Monitor: every replay handshake is matched against the next expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid && out_ready) begin
            $display("beat %0d shift %h max %h last %b", out_beat, out_shift, out_max, out_last);
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", 64'(out_beat), 64'hFFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_shift", 64'(out_shift), 64'(e.shift));
                chk("sb_max",   64'(out_max),   64'(e.mx));
                chk("sb_beat",  64'(out_beat),  64'(e.beat));
                chk("sb_last",  64'(out_last),  64'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_exps     = '0;
        in_mask     = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        x_in_valid  = 1'b0;
        x_in_exps   = '0;
        x_in_mask   = '0;
        x_in_last   = 1'b0;
        x_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single beat block.
        push(mk8(4, 9, 0, 0, 7), 7, 0, 1'b1);
        send_beat(mk8(3, -2, 7, 7, 0), 5'h1F, 1'b1);
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        chk("t1_in_ready_low",  64'(in_ready),  64'd0);
        wait_idle();

        // Three-beat block.
        push(all8(9), 10, 0, 1'b0);
        push(all8(0), 10, 1, 1'b0);
        push(all8(15), 10, 2, 1'b1);
        send_beat(all8(1), 5'h1F, 1'b0);
        send_beat(all8(10), 5'h1F, 1'b0);
        send_beat(all8(-5), 5'h1F, 1'b1);
        chk("t2_ovf_low", 64'(ovf), 64'd0);
        wait_idle();

        // Backpressure on replay beat 1 with input offered during replay.
        push(all8(2), 4, 0, 1'b0);
        push(all8(0), 4, 1, 1'b0);
        push(all8(4), 4, 2, 1'b1);
        send_beat(all8(2), 5'h1F, 1'b0);
        send_beat(all8(4), 5'h1F, 1'b0);
        send_beat(all8(0), 5'h1F, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_exps   = all8(100);
        in_mask   = 5'h1F;
        in_last   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_beat",  64'(out_beat),  64'd1);
            chk("bp_out_shift", 64'(out_shift), 64'(all8(0)));
            chk("bp_out_max",   64'(out_max),   64'd4);
            chk("bp_out_last",  64'(out_last),  64'd0);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Masked lane with a large exponent; others include the minimum exponent.
        push(mk8(133, 8, 255, 0, 133), 5, 0, 1'b1);
        send_beat(mk8(-128, -3, 127, 5, -128), 5'b11011, 1'b1);
        wait_idle();

        // All lanes masked: max is the most negative exponent, every shift saturates.
        push(all8(255), -128, 0, 1'b1);
        send_beat(mk8(1, 2, 3, 4, 5), 5'b00000, 1'b1);
        wait_idle();

        // Saturation with a 10-bit exponent instance.
        x_in_exps  = mk10(300, -100, 46, 45, 44);
        x_in_mask  = 5'h1F;
        x_in_last  = 1'b1;
        x_in_valid = 1'b1;
        chk("w10_in_ready", 64'(x_in_ready), 64'd1);
        @(posedge clk); #1;
        x_in_valid = 1'b0;
        chk("w10_out_valid", 64'(x_out_valid), 64'd1);
        chk("w10_out_max",   64'(x_out_max),   64'd300);
        chk("w10_out_shift", 64'(x_out_shift), 64'(mk8(0, 255, 254, 255, 255)));
        chk("w10_out_last",  64'(x_out_last),  64'd1);
        $display("w10 beat shift %h max %0d", x_out_shift, x_out_max);
        @(posedge clk); #1;

        // Overflow: four beats without in_last.
        push(all8(2), 2, 0, 1'b0);
        push(all8(3), 2, 1, 1'b0);
        push(all8(0), 2, 2, 1'b0);
        push(all8(1), 2, 3, 1'b1);
        send_beat(all8(0), 5'h1F, 1'b0);
        chk("ovf_early", 64'(ovf), 64'd0);
        send_beat(all8(-1), 5'h1F, 1'b0);
        send_beat(all8(2), 5'h1F, 1'b0);
        chk("ovf_before_full", 64'(ovf), 64'd0);
        send_beat(all8(1), 5'h1F, 1'b0);
        chk("ovf_pulse",      64'(ovf),       64'd1);
        chk("ovf_out_valid",  64'(out_valid), 64'd1);
        @(posedge clk); #1;
        chk("ovf_one_cycle",  64'(ovf),       64'd0);
        wait_idle();

        // Reset mid-replay after beat 0 has been consumed.
        push(all8(1), 6, 0, 1'b0);
        send_beat(all8(5), 5'h1F, 1'b0);
        send_beat(all8(6), 5'h1F, 1'b1);
        @(posedge clk); #1;
        chk("mid_beat1_shown", 64'(out_beat), 64'd1);
        reset = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        push(mk8(4, 3, 2, 1, 0), 4, 0, 1'b1);
        send_beat(mk8(0, 1, 2, 3, 4), 5'h1F, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
